alu_rr_arbiter: RTL and testbench
=================================

// Module: alu_rr_arbiter
// PURPOSE
//  Shares one combinational ALU instance (32-bit A/B, 3-bit ALU_OP, F/ZF/OF) between two requesters.
//  Round-robin arbitration, valid/ready handshake on each request port, registered result port.
//  Sits between two issuing units and the shared ALU; the ALU is instantiated inside this block.
//  Sequencing is a 3-state FSM: accept, execute, respond.
// PARAMETERS
//  PRIORITY_INIT  0  requester favoured on the first arbitration after reset (0 or 1)
// PORTS
//  clk          in   1   clock; all state updates on the rising edge
//  rst_n        in   1   reset, asynchronous, active-low
//  req0_valid   in   1   requester 0 has an operation pending
//  req0_ready   out  1   block accepts the requester 0 operation this cycle
//  req0_op      in   3   ALU_OP encoding: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB, 110 SLTU, 111 SLL (B<<A)
//  req0_a       in   32  operand A
//  req0_b       in   32  operand B
//  req1_valid   in   1   requester 1 has an operation pending
//  req1_ready   out  1   as for req0_ready
//  req1_op      in   3   as for req0_op
//  req1_a       in   32  as for req0_a
//  req1_b       in   32  as for req0_b
//  rsp_valid    out  1   response registers hold a valid result
//  rsp_ready    in   1   consumer takes the response
//  rsp_id       out  1   requester that issued the operation
//  rsp_f        out  32  ALU result F
//  rsp_zf       out  1   ALU zero flag (1 when F == 0)
//  rsp_of       out  1   ALU carry-out/overflow flag; ADD and SLL only, forced to 0 for all other ops
//  busy         out  1   FSM not in IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer = PRIORITY_INIT, operand/response registers 0. Reset mid-operation abandons the op; no response is issued.
//  FSM states:
//    IDLE: reqN_ready is driven combinationally. Only the requester chosen by the round-robin rule sees ready high.
//      Chosen requester: the pointer if its valid is 1, otherwise the other requester if its valid is 1.
//      On transfer (valid & ready), capture op, a, b and id into the operand registers and go to EXEC.
//    EXEC: the ALU is driven from the operand registers. Capture F, ZF and masked OF into the response registers. Go to RESP.
//    RESP: rsp_valid=1 and the response is held stable. On rsp_valid & rsp_ready: go to IDLE and set the pointer to ~rsp_id.
//  req0_ready and req1_ready are never high together and are 0 outside IDLE.
//  Latency: accept edge at cycle t -> rsp_valid high at t+2. Peak throughput: 1 op per 3 cycles.
//  Requester payload must stay stable while valid & !ready. Dropping valid before ready has no effect.
//  The pointer updates only on response handshake. A requester that never drops valid still alternates with the other.
//  Width rules: F is 32-bit, wraps mod 2^32. SUB is A-B mod 2^32 with OF=0. SLTU is unsigned. SLL OF is bit 32 of {OF,F}=B<<A.
//  IDLE with no valid request: stay in IDLE, busy=0, rsp_valid=0.
// TESTING
//  1. req0 AND a=F0F0F0F0 b=FF00FF00 -> accept t, rsp_valid t+2, f=F000F000 zf=0 of=0 id=0.
//  2. req0 and req1 both held valid after reset, PRIORITY_INIT=0 -> grants 0,1,0,1; rsp_ready tied 1.
//  3. ADD a=FFFFFFFF b=00000001 -> f=00000000 zf=1 of=1.
//  4. SUB a=3 b=5 -> f=FFFFFFFE zf=0 of=0; SLTU a=3 b=5 -> f=1.
//  5. rsp_ready low for 5 cycles while req1 valid -> rsp fields stable, both readies 0, no accept until handshake.
//  6. rst_n asserted in EXEC -> rsp_valid/busy/readies 0 immediately; after release IDLE, pointer=PRIORITY_INIT.

Source files
------------

// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// Each operation goes through accept (IDLE), execute (EXEC) and respond (RESP).
module alu_rr_arbiter #(
  parameter logic PRIORITY_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_f,
  output logic        rsp_zf,
  output logic        rsp_of,
  output logic        busy
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; ready never depends on anything but state, pointer and the valids.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        rr_ptr;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        id_q;

  logic        grant_any;
  logic        grant_id;
  logic        accept;
  logic        rsp_done;

  logic [32:0] alu_sum;
  logic [32:0] alu_sll;
  logic [31:0] alu_f;
  logic        alu_zf;
  logic        alu_of;

  // Pointer's requester wins if it is asking, otherwise the other one.
  assign grant_any  = req0_valid | req1_valid;
  assign grant_id   = rr_ptr ? req1_valid : ~req0_valid;
  // Gated with rst_n so readies read 0 for the whole reset window.
  assign req0_ready = rst_n && (state == IDLE) && grant_any && !grant_id;
  assign req1_ready = rst_n && (state == IDLE) && grant_any && grant_id;
  assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign rsp_done   = (state == RESP) && rsp_ready;

  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);

  always_comb begin
    alu_sum = {1'b0, a_q} + {1'b0, b_q};
    alu_sll = {1'b0, b_q} << a_q;
    alu_f   = 32'd0;
    alu_of  = 1'b0;
    case (op_q)
      3'b000: alu_f = a_q & b_q;
      3'b001: alu_f = a_q | b_q;
      3'b010: alu_f = a_q ^ b_q;
      3'b011: alu_f = ~(a_q | b_q);
      3'b100: begin
        alu_f  = alu_sum[31:0];
        alu_of = alu_sum[32];
      end
      3'b101: alu_f = a_q - b_q;
      3'b110: alu_f = {31'd0, (a_q < b_q)};
      3'b111: begin
        alu_f  = alu_sll[31:0];
        alu_of = alu_sll[32];
      end
      default: alu_f = 32'd0;
    endcase
    alu_zf = (alu_f == 32'd0);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= PRIORITY_INIT;
    end else begin
      state <= state_next;
      if (rsp_done) rr_ptr <= ~rsp_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= 3'd0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
      id_q <= 1'b0;
    end else if (accept) begin
      op_q <= grant_id ? req1_op : req0_op;
      a_q  <= grant_id ? req1_a  : req0_a;
      b_q  <= grant_id ? req1_b  : req0_b;
      id_q <= grant_id;
    end
  end

  // Response registers load only in EXEC and stay frozen through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id <= 1'b0;
      rsp_f  <= 32'd0;
      rsp_zf <= 1'b0;
      rsp_of <= 1'b0;
    end else if (state == EXEC) begin
      rsp_id <= id_q;
      rsp_f  <= alu_f;
      rsp_zf <= alu_zf;
      rsp_of <= alu_of;
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: directed scenarios plus a randomized run checked
// against an arithmetic ALU model and an expected-response queue.
module tb_alu_rr_arbiter;

  localparam logic PRIO = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [2:0]  req0_op = 3'd0;
  logic [31:0] req0_a = 32'd0;
  logic [31:0] req0_b = 32'd0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [2:0]  req1_op = 3'd0;
  logic [31:0] req1_a = 32'd0;
  logic [31:0] req1_b = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_id;
  logic [31:0] rsp_f;
  logic        rsp_zf;
  logic        rsp_of;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected response: {id, f[31:0], zf, of}
  logic [34:0] exp_q[$];

  alu_rr_arbiter #(.PRIORITY_INIT(PRIO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_f(rsp_f), .rsp_zf(rsp_zf), .rsp_of(rsp_of), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [34:0] alu_model(input logic id, input logic [2:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] r;
    logic        of;
    ua = {32'd0, a};
    ub = {32'd0, b};
    of = 1'b0;
    case (op)
      3'd0: r = ua & ub;
      3'd1: r = ua | ub;
      3'd2: r = ua ^ ub;
      3'd3: r = ~(ua | ub);
      3'd4: begin r = ua + ub; of = (r >= 64'h1_0000_0000); end
      3'd5: r = ua - ub;
      3'd6: r = (ua < ub) ? 64'd1 : 64'd0;
      default: begin r = (ua >= 64'd33) ? 64'd0 : (ub << ua); of = r[32]; end
    endcase
    return {id, r[31:0], (r[31:0] == 32'd0), of};
  endfunction

  task automatic gen_op(output logic [2:0] op, output logic [31:0] a, output logic [31:0] b);
    op = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 3))
      0:       begin a = 32'hFFFF_FFFF; b = $urandom; end
      1:       begin a = $urandom; b = 32'd0; end
      default: begin a = $urandom; b = $urandom; end
    endcase
    if (op == 3'd7) a = 32'($urandom_range(0, 40));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({req0_ready, req1_ready, rsp_valid, busy, rsp_id, rsp_zf, rsp_of} !== 7'd0 || rsp_f !== 32'd0)
      begin n_fail++; $display("FAIL reset_outputs got rdy=%b%b vld=%b busy=%b id=%b f=%h zf=%b of=%b exp all 0",
        req0_ready, req1_ready, rsp_valid, busy, rsp_id, rsp_f, rsp_zf, rsp_of); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0)
      begin n_fail++; $display("FAIL reset_release_idle got busy=%b vld=%b exp 0 0", busy, rsp_valid); end
    @(posedge clk); #1;
  endtask

  // Single op from one requester while the other is idle; checks latency and result.
  task automatic run_op(input logic id, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ef, input logic ezf,
                        input logic eof, input string name);
    int waited;
    if (id) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    rsp_ready = 1'b0;
    waited = 0;
    @(negedge clk);
    while (((id ? req1_ready : req0_ready) !== 1'b1) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (waited != 0) begin
      n_fail++; $display("FAIL %s_accept got wait=%0d exp 0", name, waited);
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0)
      begin n_fail++; $display("FAIL %s_exec got vld=%b busy=%b rdy=%b%b exp 0 1 00",
        name, rsp_valid, busy, req0_ready, req1_ready); end
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || {rsp_id, rsp_f, rsp_zf, rsp_of} !== {id, ef, ezf, eof})
      begin n_fail++; $display("FAIL %s_rsp got vld=%b id=%b f=%h zf=%b of=%b exp 1 %b %h %b %b",
        name, rsp_valid, rsp_id, rsp_f, rsp_zf, rsp_of, id, ef, ezf, eof); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0)
      begin n_fail++; $display("FAIL %s_done got vld=%b busy=%b exp 0 0", name, rsp_valid, busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_ops();
    run_op(1'b0, 3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, "and");
    run_op(1'b1, 3'd4, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, "add_wrap");
    run_op(1'b0, 3'd5, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub");
    run_op(1'b1, 3'd6, 32'd3, 32'd5, 32'h0000_0001, 1'b0, 1'b0, "sltu");
    run_op(1'b0, 3'd7, 32'd1, 32'h8000_0001, 32'h0000_0002, 1'b0, 1'b1, "sll_carry");
    run_op(1'b1, 3'd3, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, "nor_zero");
    run_op(1'b0, 3'd2, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, "xor_zero");
  endtask

  task automatic test_back_to_back();
    int ids[$];
    int cycs[$];
    do_reset();
    req0_valid = 1'b1; req0_op = 3'd4; req0_a = 32'd1; req0_b = 32'd2;
    req1_valid = 1'b1; req1_op = 3'd2; req1_a = 32'hA5A5_A5A5; req1_b = 32'h5A5A_5A5A;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && ids.size() < 4; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (req0_ready === 1'b1 && req1_ready === 1'b1)
        begin n_fail++; $display("FAIL b2b_exclusive got rdy=11 exp one-hot or 00"); end
      if (req0_ready === 1'b1) begin ids.push_back(0); cycs.push_back(cyc); end
      if (req1_ready === 1'b1) begin ids.push_back(1); cycs.push_back(cyc); end
    end
    n_checks++;
    if (ids.size() != 4) begin n_fail++; $display("FAIL b2b_grants got %0d exp 4", ids.size()); end
    for (int i = 0; i < ids.size(); i++) begin
      n_checks++;
      if (ids[i] != (i % 2)) begin n_fail++; $display("FAIL b2b_order[%0d] got %0d exp %0d", i, ids[i], i % 2); end
      if (i > 0) begin
        n_checks++;
        if (cycs[i] - cycs[i-1] != 3)
          begin n_fail++; $display("FAIL b2b_spacing[%0d] got %0d exp 3", i, cycs[i] - cycs[i-1]); end
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic [34:0] e;
    req0_valid = 1'b1; req0_op = 3'd1; req0_a = 32'h1234_0000; req0_b = 32'h0000_5678;
    @(negedge clk);
    n_checks++;
    if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL stall_accept0 got %b exp 1", req0_ready); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 3'd6; req1_a = 32'd5; req1_b = 32'd3;
    rsp_ready = 1'b0;
    @(negedge clk);
    e = {1'b0, 32'h1234_5678, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || {rsp_id, rsp_f, rsp_zf, rsp_of} !== e || req0_ready !== 1'b0 || req1_ready !== 1'b0)
        begin n_fail++; $display("FAIL stall_hold[%0d] got vld=%b rsp=%h rdy=%b%b exp 1 %h 00",
          i, rsp_valid, {rsp_id, rsp_f, rsp_zf, rsp_of}, req0_ready, req1_ready, e); end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0)
      begin n_fail++; $display("FAIL stall_accept1 got rdy=%b%b exp 01", req0_ready, req1_ready); end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || {rsp_id, rsp_f, rsp_zf, rsp_of} !== {1'b1, 32'd0, 1'b1, 1'b0})
      begin n_fail++; $display("FAIL stall_rsp1 got vld=%b rsp=%h exp 1 %h",
        rsp_valid, {rsp_id, rsp_f, rsp_zf, rsp_of}, {1'b1, 32'd0, 1'b1, 1'b0}); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_exec();
    run_op(1'b0, 3'd0, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0, 1'b0, "pre_rst");
    req0_valid = 1'b1; req0_op = 3'd4; req0_a = 32'd7; req0_b = 32'd8;
    req1_valid = 1'b1; req1_op = 3'd4; req1_a = 32'd9; req1_b = 32'd10;
    @(negedge clk);
    n_checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0)
      begin n_fail++; $display("FAIL rst_pre_grant got rdy=%b%b exp 01", req0_ready, req1_ready); end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0)
      begin n_fail++; $display("FAIL rst_in_exec got vld=%b busy=%b rdy=%b%b exp 0 0 00",
        rsp_valid, busy, req0_ready, req1_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || busy !== 1'b0)
      begin n_fail++; $display("FAIL rst_ptr_init got rdy=%b%b busy=%b exp 10 0", req0_ready, req1_ready, busy); end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0)
        begin n_fail++; $display("FAIL rst_no_rsp[%0d] got vld=%b busy=%b exp 0 0", i, rsp_valid, busy); end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    int          phase;
    logic        ptr;
    logic [1:0]  vv;
    logic        acc;
    logic        acc_id;
    logic        hs;
    logic [34:0] e;
    logic [1:0]  exp_rdy;
    do_reset();
    exp_q.delete();
    phase = 0;
    ptr = PRIO;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      vv = {req1_valid, req0_valid};
      acc = 1'b0;
      acc_id = 1'b0;
      if (phase == 0 && vv != 2'b00) begin
        acc = 1'b1;
        acc_id = vv[ptr] ? ptr : ~ptr;
      end
      exp_rdy = acc ? (acc_id ? 2'b10 : 2'b01) : 2'b00;
      n_checks++;
      if ({req1_ready, req0_ready} !== exp_rdy)
        begin n_fail++; $display("FAIL rnd_ready[%0d] got %b exp %b", cyc, {req1_ready, req0_ready}, exp_rdy); end
      n_checks++;
      if (busy !== (phase != 0) || rsp_valid !== (phase == 2))
        begin n_fail++; $display("FAIL rnd_state[%0d] got busy=%b vld=%b exp %0d %0d",
          cyc, busy, rsp_valid, phase != 0, phase == 2); end
      if (phase == 2) begin
        n_checks++;
        if (exp_q.size() == 0 || {rsp_id, rsp_f, rsp_zf, rsp_of} !== exp_q[0])
          begin n_fail++; $display("FAIL rnd_rsp[%0d] got %h exp %h", cyc,
            {rsp_id, rsp_f, rsp_zf, rsp_of}, (exp_q.size() != 0) ? exp_q[0] : 35'd0); end
      end
      hs = (phase == 2) && rsp_ready;
      @(posedge clk);
      if (acc) begin
        exp_q.push_back(acc_id ? alu_model(1'b1, req1_op, req1_a, req1_b)
                               : alu_model(1'b0, req0_op, req0_a, req0_b));
        phase = 1;
      end else if (phase == 1) begin
        phase = 2;
      end else if (hs) begin
        e = exp_q.pop_front();
        ptr = ~e[34];
        phase = 0;
      end
      #1;
      if (req0_valid) begin
        if (acc && !acc_id) begin
          if ($urandom_range(0, 1) == 1) gen_op(req0_op, req0_a, req0_b);
          else req0_valid = 1'b0;
        end else if ($urandom_range(0, 15) == 0) req0_valid = 1'b0;
      end else if ($urandom_range(0, 9) < 4) begin
        req0_valid = 1'b1;
        gen_op(req0_op, req0_a, req0_b);
      end
      if (req1_valid) begin
        if (acc && acc_id) begin
          if ($urandom_range(0, 1) == 1) gen_op(req1_op, req1_a, req1_b);
          else req1_valid = 1'b0;
        end else if ($urandom_range(0, 15) == 0) req1_valid = 1'b0;
      end else if ($urandom_range(0, 9) < 4) begin
        req1_valid = 1'b1;
        gen_op(req1_op, req1_a, req1_b);
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_ops();
    test_back_to_back();
    test_stall();
    test_reset_exec();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
